wb_writeback_unit: RTL

- Write side of the integer register file: final MIPS pipeline stage that drives the file's single write port.
- Accepts retiring instructions from the MEM stage and selects ALU result, load data or link address.
- Performs byte/halfword load extraction and waits on a variable-latency data memory.
- Presents one registered write per retiring instruction, stable for a full clock period, so the register file's negedge capture always sees settled values.

---
 rtl/wb_writeback_unit_if.sv | 24 ++
 rtl/wb_writeback_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/wb_writeback_unit_if.sv
// rtl/wb_writeback_unit_if.sv - MEM-stage to writeback retire handshake
interface wb_writeback_unit_if;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_regwrite;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wbsel;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_pc_plus8;
  logic [1:0]  mem_load_size;
  logic        mem_load_signed;

  modport master (
    output mem_valid, mem_regwrite, mem_rd, mem_wbsel, mem_alu_result,
           mem_pc_plus8, mem_load_size, mem_load_signed,
    input  mem_ready
  );

  modport slave (
    input  mem_valid, mem_regwrite, mem_rd, mem_wbsel, mem_alu_result,
           mem_pc_plus8, mem_load_size, mem_load_signed,
    output mem_ready
  );
endinterface

// File: rtl/wb_writeback_unit.sv
// rtl/wb_writeback_unit.sv - register file write port driver with load extraction
module wb_writeback_unit #(
  parameter bit BIG_ENDIAN   = 1'b1,
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  wb_writeback_unit_if.slave         mem,
  input  logic                       dmem_rvalid,
  input  logic [31:0]                dmem_rdata,
  output logic [4:0]                 REG_address_wr,
  output logic                       REG_write_1,
  output logic [31:0]                REG_data_wb_in1,
  output logic                       wb_stall,
  output logic                       err_timeout,
  output logic                       err_align,
  input  logic                       err_clr
);

  typedef enum logic [0:0] {IDLE, WAIT_LOAD} state_t;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [4:0]  l_rd, l_rd_nxt;
  logic        l_regwrite, l_regwrite_nxt;
  logic [1:0]  l_size, l_size_nxt;
  logic        l_signed, l_signed_nxt;
  logic [1:0]  l_off, l_off_nxt;
  logic        wr_nxt;
  logic [4:0]  addr_nxt;
  logic [31:0] data_nxt;
  logic        set_align, set_timeout;
  logic        accept, misaligned;
  logic [1:0]  off;

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] size,
                                          input logic [1:0] offs, input logic sgn);
    logic [1:0]  lane;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    // Big-endian byte at offset k lives in LSB-relative lane 3-k.
    lane = BIG_ENDIAN ? ~offs : offs;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = (offs[1] ^ BIG_ENDIAN) ? w[31:16] : w[15:0];
    case (size)
      2'b00:   r = {{24{sgn & b[7]}}, b};
      2'b01:   r = {{16{sgn & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  assign accept     = mem.mem_valid && (state == IDLE);
  assign off        = mem.mem_alu_result[1:0];
  assign misaligned = (mem.mem_load_size == 2'b01) ? off[0] :
                      (mem.mem_load_size == 2'b00) ? 1'b0 : (off != 2'b00);

  assign mem.mem_ready = (state == IDLE);
  assign wb_stall      = (state != IDLE);

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    l_rd_nxt       = l_rd;
    l_regwrite_nxt = l_regwrite;
    l_size_nxt     = l_size;
    l_signed_nxt   = l_signed;
    l_off_nxt      = l_off;
    wr_nxt         = 1'b0;
    addr_nxt       = REG_address_wr;
    data_nxt       = REG_data_wb_in1;
    set_align      = 1'b0;
    set_timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          case (mem.mem_wbsel)
            WB_ALU, WB_LINK: begin
              addr_nxt = mem.mem_rd;
              data_nxt = (mem.mem_wbsel == WB_LINK) ? mem.mem_pc_plus8 : mem.mem_alu_result;
              wr_nxt   = mem.mem_regwrite && (mem.mem_rd != 5'd0);
            end
            WB_LOAD: begin
              if (misaligned) begin
                set_align = 1'b1;
              end else if (dmem_rvalid) begin
                addr_nxt = mem.mem_rd;
                data_nxt = extract(dmem_rdata, mem.mem_load_size, off, mem.mem_load_signed);
                wr_nxt   = mem.mem_regwrite && (mem.mem_rd != 5'd0);
              end else begin
                l_rd_nxt       = mem.mem_rd;
                l_regwrite_nxt = mem.mem_regwrite;
                l_size_nxt     = mem.mem_load_size;
                l_signed_nxt   = mem.mem_load_signed;
                l_off_nxt      = off;
                cnt_nxt        = 8'd1;
                state_nxt      = WAIT_LOAD;
              end
            end
            default: ;
          endcase
        end
      end
      WAIT_LOAD: begin
        // Data arriving on the last allowed cycle still counts as success.
        if (dmem_rvalid) begin
          addr_nxt  = l_rd;
          data_nxt  = extract(dmem_rdata, l_size, l_off, l_signed);
          wr_nxt    = l_regwrite && (l_rd != 5'd0);
          cnt_nxt   = 8'd0;
          state_nxt = IDLE;
        end else if (cnt == 8'(LOAD_TIMEOUT)) begin
          set_timeout = 1'b1;
          cnt_nxt     = 8'd0;
          state_nxt   = IDLE;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt             <= 8'd0;
      l_rd            <= 5'd0;
      l_regwrite      <= 1'b0;
      l_size          <= 2'b00;
      l_signed        <= 1'b0;
      l_off           <= 2'b00;
      REG_write_1     <= 1'b0;
      REG_address_wr  <= 5'd0;
      REG_data_wb_in1 <= 32'd0;
      err_timeout     <= 1'b0;
      err_align       <= 1'b0;
    end else begin
      cnt             <= cnt_nxt;
      l_rd            <= l_rd_nxt;
      l_regwrite      <= l_regwrite_nxt;
      l_size          <= l_size_nxt;
      l_signed        <= l_signed_nxt;
      l_off           <= l_off_nxt;
      REG_write_1     <= wr_nxt;
      REG_address_wr  <= addr_nxt;
      REG_data_wb_in1 <= data_nxt;
      err_timeout     <= set_timeout | (err_timeout & ~err_clr);
      err_align       <= set_align | (err_align & ~err_clr);
    end
  end

endmodule
